pipeline_hazard_ctrl: RTL and testbench
=======================================

// Module: pipeline_hazard_ctrl
// PURPOSE
//  Central sequencer for the five-stage pipeline. Drives PC update, the write-enables
//  of the IF/ID, ID/EX, EX/MEM and MEM/WB transfer registers, and their bubble
//  (flush) controls. Resolves load-use stalls, branch-taken flushes, multi-cycle
//  memory waits and rdy_in freezes. Keeps a saturating stall-cycle counter.
// PARAMETERS
//  REG_IDX_W  5   register index width
//  CNT_W      16  stall counter width
// PORTS
//  clk               in   1          system clock; all state changes on posedge
//  rst               in   1          asynchronous, active-high reset
//  rdy_in            in   1          global ready; 0 freezes the whole pipeline
//  id_rs1_idx        in   REG_IDX_W  rs1 index of instruction in IF/ID
//  id_rs2_idx        in   REG_IDX_W  rs2 index of instruction in IF/ID
//  id_uses_rs1       in   1          IF/ID instruction reads rs1
//  id_uses_rs2       in   1          IF/ID instruction reads rs2
//  ex_is_load        in   1          ID/EX instruction is a load
//  ex_rd             in   REG_IDX_W  destination of ID/EX instruction
//  mem_branch_taken  in   1          EX/MEM branch resolved taken
//  mem_req           in   1          MEM stage is issuing a memory access
//  mem_done          in   1          memory access completes this cycle
//  pc_we             out  1          PC register load enable
//  pc_sel            out  1          1: PC <= branch target (EX/MEM offset_pc); 0: sequential
//  if_id_we          out  1          IF/ID load enable
//  id_ex_we          out  1          ID/EX load enable
//  ex_mem_we         out  1          EX/MEM load enable
//  mem_wb_we         out  1          MEM/WB load enable
//  if_id_flush       out  1          with if_id_we: load bubble instead of data
//  id_ex_flush       out  1          with id_ex_we: load bubble (all stage-state fields 0)
//  ex_mem_flush      out  1          with ex_mem_we: load bubble
//  stall_cnt         out  CNT_W      cycles with any we=0 while rdy_in=1 (saturating)
// BEHAVIOUR
//  States (2-bit reg): IDLE=0, RUN=1, MEM_WAIT=2. Outputs combinational from state+inputs.
//  Reset (async, any time incl. mid-wait): state<=IDLE, stall_cnt<=0. While rst=1 or in
//   IDLE: all *_we=0, all *_flush=1, pc_sel=0. IDLE->RUN on first posedge with rdy_in=1.
//  rdy_in=0 (any state): all *_we=0, all *_flush=0, pc_sel=0; state and stall_cnt hold.
//  RUN priority, highest first (rdy_in=1):
//   1 freeze: mem_req=1 & mem_done=0 -> all we=0, flush=0; next MEM_WAIT.
//   2 branch: mem_branch_taken=1 -> all we=1, pc_sel=1, if_id/id_ex/ex_mem_flush=1.
//     Branch overrides load-use in the same cycle (hazard instruction is squashed).
//   3 load-use: hz = ex_is_load & ex_rd!=0 & ((id_uses_rs1 & id_rs1_idx==ex_rd) |
//     (id_uses_rs2 & id_rs2_idx==ex_rd)) -> pc_we=0, if_id_we=0, id_ex_we=1,
//     id_ex_flush=1, ex_mem_we=mem_wb_we=1. Exactly one bubble per load-use pair.
//   4 normal: all we=1, all flush=0, pc_sel=0.
//   mem_req=1 & mem_done=1 in the same cycle: single-cycle access, no freeze; evaluate 2-4.
//  MEM_WAIT: mem_done=0 -> full freeze (as rule 1), stay. mem_done=1 -> evaluate rules 2-4
//   exactly as RUN (mem_req ignored), next RUN. EX/MEM is held during the wait, so a
//   taken branch in the waiting instruction is applied on the completion cycle.
//  stall_cnt: +1 on each posedge with rdy_in=1, state!=IDLE and any *_we=0; saturates at
//   2^CNT_W-1 (no wrap). Flush-only cycles (rule 2) do not count.
//  pc_sel is 0 whenever pc_we=0. Flush outputs are don't-care to consumers when the
//   paired we=0, but must equal the values above.
// TESTING
//  1 rst=1 mid MEM_WAIT -> same cycle all we=0, flush=1, stall_cnt=0; rst=0, rdy_in=1 ->
//    RUN after one posedge, all we=1.
//  2 ex_is_load=1, ex_rd=5, id_uses_rs2=1, id_rs2_idx=5 -> pc_we=0, if_id_we=0,
//    id_ex_flush=1 one cycle; stall_cnt 0->1. Same with ex_rd=0 -> no stall.
//  3 mem_branch_taken=1 with load-use also true -> pc_sel=1, all we=1, three flushes=1,
//    stall_cnt unchanged.
//  4 mem_req=1, mem_done=0 for 3 cycles then 1 -> 3 freeze cycles (state MEM_WAIT),
//    advance on 4th, stall_cnt +3; mem_req=mem_done=1 -> no freeze.
//  5 MEM_WAIT with mem_branch_taken=1, mem_done rises -> that cycle pc_sel=1, flushes=1, ->RUN.
//  6 rdy_in=0 for 2 cycles during load-use -> all we=0, flush=0, stall_cnt held; CNT_W=2
//    with 5 stalls -> stall_cnt stops at 3.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Central hazard sequencer for the five-stage pipeline: stage-register write enables,
// bubble controls, PC select, and a saturating count of stalled cycles.
module pipeline_hazard_ctrl #(
    parameter int unsigned REG_IDX_W = 5,
    parameter int unsigned CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy_in,
    input  logic [REG_IDX_W-1:0] id_rs1_idx,
    input  logic [REG_IDX_W-1:0] id_rs2_idx,
    input  logic                 id_uses_rs1,
    input  logic                 id_uses_rs2,
    input  logic                 ex_is_load,
    input  logic [REG_IDX_W-1:0] ex_rd,
    input  logic                 mem_branch_taken,
    input  logic                 mem_req,
    input  logic                 mem_done,
    output logic                 pc_we,
    output logic                 pc_sel,
    output logic                 if_id_we,
    output logic                 id_ex_we,
    output logic                 ex_mem_we,
    output logic                 mem_wb_we,
    output logic                 if_id_flush,
    output logic                 id_ex_flush,
    output logic                 ex_mem_flush,
    output logic [CNT_W-1:0]     stall_cnt
);

    typedef enum logic [1:0] {
        StIdle    = 2'd0,
        StRun     = 2'd1,
        StMemWait = 2'd2
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             load_use;
    logic             advance;
    logic             any_hold;

    always_comb begin
        state_d      = state_q;
        advance      = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = 1'b0;
        if_id_we     = 1'b0;
        id_ex_we     = 1'b0;
        ex_mem_we    = 1'b0;
        mem_wb_we    = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_flush = 1'b0;

        load_use = ex_is_load && (ex_rd != '0) &&
                   ((id_uses_rs1 && (id_rs1_idx == ex_rd)) ||
                    (id_uses_rs2 && (id_rs2_idx == ex_rd)));

        if (rst) begin
            if_id_flush  = 1'b1;
            id_ex_flush  = 1'b1;
            ex_mem_flush = 1'b1;
        end else if (rdy_in) begin
            case (state_q)
                StIdle: begin
                    if_id_flush  = 1'b1;
                    id_ex_flush  = 1'b1;
                    ex_mem_flush = 1'b1;
                    state_d      = StRun;
                end
                StRun: begin
                    if (mem_req && !mem_done) begin
                        state_d = StMemWait;
                    end else begin
                        advance = 1'b1;
                    end
                end
                StMemWait: begin
                    // mem_req is ignored here: the waiting access is the one completing.
                    if (mem_done) begin
                        advance = 1'b1;
                        state_d = StRun;
                    end
                end
                default: state_d = StIdle;
            endcase
        end

        if (advance) begin
            pc_we     = 1'b1;
            if_id_we  = 1'b1;
            id_ex_we  = 1'b1;
            ex_mem_we = 1'b1;
            mem_wb_we = 1'b1;
            if (mem_branch_taken) begin
                // Squashes the younger instructions, including any load-use victim.
                pc_sel       = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_flush = 1'b1;
            end else if (load_use) begin
                pc_we       = 1'b0;
                if_id_we    = 1'b0;
                id_ex_flush = 1'b1;
            end
        end

        any_hold    = !(pc_we && if_id_we && id_ex_we && ex_mem_we && mem_wb_we);
        stall_cnt_d = stall_cnt_q;
        if (!rst && rdy_in && (state_q != StIdle) && any_hold && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: a behavioural model checked every cycle against two
// instances (16-bit and 2-bit counters) plus directed literal expectations.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rdy_in;
    logic [4:0] id_rs1_idx, id_rs2_idx, ex_rd;
    logic       id_uses_rs1, id_uses_rs2, ex_is_load;
    logic       mem_branch_taken, mem_req, mem_done;

    logic        pc_we, pc_sel, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
    logic        if_id_flush, id_ex_flush, ex_mem_flush;
    logic [15:0] stall_cnt;
    logic [8:0]  o2;
    logic [1:0]  stall_cnt2;
    logic [8:0]  o1;

    int nchecks = 0;
    int nerr    = 0;

    always #5 clk = ~clk;

    // Output vector order: pc_we pc_sel if_id_we id_ex_we ex_mem_we mem_wb_we
    //                      if_id_flush id_ex_flush ex_mem_flush
    assign o1 = {pc_we, pc_sel, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
                 if_id_flush, id_ex_flush, ex_mem_flush};

    pipeline_hazard_ctrl #(.REG_IDX_W(5), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .rdy_in(rdy_in),
        .id_rs1_idx(id_rs1_idx), .id_rs2_idx(id_rs2_idx),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .mem_branch_taken(mem_branch_taken), .mem_req(mem_req), .mem_done(mem_done),
        .pc_we(pc_we), .pc_sel(pc_sel), .if_id_we(if_id_we), .id_ex_we(id_ex_we),
        .ex_mem_we(ex_mem_we), .mem_wb_we(mem_wb_we), .if_id_flush(if_id_flush),
        .id_ex_flush(id_ex_flush), .ex_mem_flush(ex_mem_flush), .stall_cnt(stall_cnt)
    );

    pipeline_hazard_ctrl #(.REG_IDX_W(5), .CNT_W(2)) dut_w2 (
        .clk(clk), .rst(rst), .rdy_in(rdy_in),
        .id_rs1_idx(id_rs1_idx), .id_rs2_idx(id_rs2_idx),
        .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
        .ex_is_load(ex_is_load), .ex_rd(ex_rd),
        .mem_branch_taken(mem_branch_taken), .mem_req(mem_req), .mem_done(mem_done),
        .pc_we(o2[8]), .pc_sel(o2[7]), .if_id_we(o2[6]), .id_ex_we(o2[5]),
        .ex_mem_we(o2[4]), .mem_wb_we(o2[3]), .if_id_flush(o2[2]),
        .id_ex_flush(o2[1]), .ex_mem_flush(o2[0]), .stall_cnt(stall_cnt2)
    );

    // ---------------- behavioural model ----------------
    localparam logic [8:0] IdleV   = 9'b000000111;
    localparam logic [8:0] FrozenV = 9'b000000000;
    localparam logic [8:0] NormV   = 9'b101111000;
    localparam logic [8:0] BranchV = 9'b111111111;
    localparam logic [8:0] BubbleV = 9'b000111010;

    int         m_mode = 0; // 0 idle, 1 running, 2 waiting on memory
    int         m_cnt  = 0;
    logic [8:0] m_e;

    function automatic logic [8:0] model_out(input int mode);
        logic hz, stuck;
        hz = ex_is_load && (ex_rd != 0) &&
             ((id_uses_rs1 && id_rs1_idx == ex_rd) || (id_uses_rs2 && id_rs2_idx == ex_rd));
        stuck = (mode == 2) ? !mem_done : (mem_req && !mem_done);
        if (rst)                   return IdleV;
        if (!rdy_in)               return FrozenV;
        if (mode == 0)             return IdleV;
        if (stuck)                 return FrozenV;
        if (mem_branch_taken)      return BranchV;
        if (hz)                    return BubbleV;
        return NormV;
    endfunction

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode <= 0;
            m_cnt  <= 0;
        end else if (rdy_in) begin
            m_e = model_out(m_mode);
            if (m_mode != 0 && !(m_e[8] && m_e[6] && m_e[5] && m_e[4] && m_e[3]))
                m_cnt <= m_cnt + 1;
            if (m_mode == 0)                              m_mode <= 1;
            else if (m_mode == 1 && mem_req && !mem_done) m_mode <= 2;
            else if (m_mode == 2 && mem_done)             m_mode <= 1;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchecks++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        chk("model_out", {23'd0, o1}, {23'd0, model_out(m_mode)});
        chk("model_out_w2", {23'd0, o2}, {23'd0, model_out(m_mode)});
        chk("model_cnt", {16'd0, stall_cnt}, sat(m_cnt, 65535));
        chk("model_cnt_w2", {30'd0, stall_cnt2}, sat(m_cnt, 3));
    end

    // ---------------- directed stimulus ----------------
    task automatic quiet();
        rdy_in = 1'b1; id_rs1_idx = '0; id_rs2_idx = '0; ex_rd = '0;
        id_uses_rs1 = 1'b0; id_uses_rs2 = 1'b0; ex_is_load = 1'b0;
        mem_branch_taken = 1'b0; mem_req = 1'b0; mem_done = 1'b0;
    endtask

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string nm, input logic [8:0] exp);
        chk(nm, {23'd0, o1}, {23'd0, exp});
    endtask

    initial begin
        quiet();
        repeat (2) @(posedge clk);
        @(negedge clk); lit("rst_out", IdleV); chk("rst_cnt", {16'd0, stall_cnt}, 0);
        nxt(); rst = 1'b0;
        @(negedge clk); lit("idle_out", IdleV);
        nxt();
        @(negedge clk); lit("run_normal", NormV);

        // load-use on rs2
        nxt(); ex_is_load = 1'b1; ex_rd = 5'd5; id_uses_rs2 = 1'b1; id_rs2_idx = 5'd5;
        @(negedge clk); lit("lu_bubble", BubbleV); chk("lu_cnt_pre", {16'd0, stall_cnt}, 0);
        nxt(); ex_is_load = 1'b0;
        @(negedge clk); lit("lu_release", NormV); chk("lu_cnt_post", {16'd0, stall_cnt}, 1);
        nxt(); ex_is_load = 1'b1; ex_rd = 5'd0; id_rs2_idx = 5'd0;
        @(negedge clk); lit("lu_x0", NormV);

        // branch overrides load-use
        nxt(); ex_rd = 5'd5; id_rs2_idx = 5'd5; mem_branch_taken = 1'b1;
        @(negedge clk); lit("br_over_lu", BranchV);
        nxt(); quiet();
        @(negedge clk); chk("br_cnt", {16'd0, stall_cnt}, 1);

        // three-cycle memory wait
        nxt(); mem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); lit("mw_freeze", FrozenV);
            nxt();
        end
        mem_done = 1'b1;
        @(negedge clk); lit("mw_done", NormV); chk("mw_cnt", {16'd0, stall_cnt}, 4);
        nxt();
        @(negedge clk); lit("single_cycle", NormV);
        nxt(); quiet();
        @(negedge clk); chk("single_cnt", {16'd0, stall_cnt}, 4);

        // taken branch on wait completion
        nxt(); mem_req = 1'b1;
        @(negedge clk); lit("mwb_freeze0", FrozenV);
        nxt(); mem_branch_taken = 1'b1;
        @(negedge clk); lit("mwb_freeze1", FrozenV);
        nxt(); mem_done = 1'b1;
        @(negedge clk); lit("mwb_branch", BranchV); chk("mwb_cnt", {16'd0, stall_cnt}, 6);
        nxt(); quiet();
        @(negedge clk); lit("mwb_run", NormV);

        // rdy_in low during load-use, then saturation of the narrow counter
        nxt(); ex_is_load = 1'b1; ex_rd = 5'd5; id_uses_rs1 = 1'b1; id_rs1_idx = 5'd5;
        rdy_in = 1'b0;
        @(negedge clk); lit("rdy0_a", FrozenV);
        nxt();
        @(negedge clk); lit("rdy0_b", FrozenV); chk("rdy0_cnt", {16'd0, stall_cnt}, 6);
        nxt(); rdy_in = 1'b1;
        @(negedge clk); lit("rdy1_lu", BubbleV); chk("sat_w2", {30'd0, stall_cnt2}, 3);
        nxt(); quiet();
        @(negedge clk); chk("cnt_7", {16'd0, stall_cnt}, 7); chk("sat_w2_b", {30'd0, stall_cnt2}, 3);

        // reset in the middle of a memory wait
        nxt(); mem_req = 1'b1;
        nxt();
        @(negedge clk); lit("pre_rst_freeze", FrozenV);
        #2 rst = 1'b1;
        #1 lit("rst_mid", IdleV); chk("rst_mid_cnt", {16'd0, stall_cnt}, 0);
        nxt(); rst = 1'b0; quiet();
        @(negedge clk); lit("post_rst_idle", IdleV);
        nxt();
        @(negedge clk); lit("post_rst_run", NormV);

        nxt();
        $display("Simulation finished: %0d checks, %0d errors", nchecks, nerr);
        $finish;
    end

endmodule
